// File: rtl/aes_block_loader.sv
// aes_block_loader: valid/ready front-end that resets a byte-serial AES core, streams key and plaintext
// into it MSB first, waits RUN_CYCLES clocks and captures the ciphertext. Define AES_LOADER_CNT_EN for blk_count.
module aes_block_loader #(
    parameter int RUN_CYCLES = 800
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_in,
    input  logic [127:0] pt_in,
    output logic         core_rst,
    output logic [7:0]   key_byte,
    output logic [7:0]   msg_byte,
    input  logic [127:0] cipher_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct_out
`ifdef AES_LOADER_CNT_EN
    ,
    output logic [15:0]  blk_count
`endif
);
    localparam int WCW = $clog2(RUN_CYCLES + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CORE_RST, STREAM, WAIT, DONE} state_t;

    state_t         state;
    logic [127:0]   key_sr;
    logic [127:0]   pt_sr;
    logic [3:0]     byte_cnt;
    logic [WCW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            key_sr   <= '0;
            pt_sr    <= '0;
            byte_cnt <= '0;
            wait_cnt <= '0;
            ct_out   <= '0;
`ifdef AES_LOADER_CNT_EN
            blk_count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        key_sr <= key_in;
                        pt_sr  <= pt_in;
                        state  <= CORE_RST;
                    end
                end
                CORE_RST: begin
                    byte_cnt <= '0;
                    wait_cnt <= '0;
                    state    <= STREAM;
                end
                STREAM: begin
                    key_sr   <= {key_sr[119:0], 8'h00};
                    pt_sr    <= {pt_sr[119:0], 8'h00};
                    byte_cnt <= byte_cnt + 4'd1;
                    if (byte_cnt == 4'd15) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // Sample the core on the last of RUN_CYCLES wait clocks.
                    if (wait_cnt == WAIT_LAST) begin
                        ct_out <= cipher_in;
                        state  <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        key_sr <= '0;
                        pt_sr  <= '0;
                        state  <= IDLE;
`ifdef AES_LOADER_CNT_EN
                        blk_count <= blk_count + 16'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state only; no path from in_valid or out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign core_rst  = (state == IDLE) || (state == CORE_RST);
    assign key_byte  = (state == STREAM) ? key_sr[127:120] : 8'h00;
    assign msg_byte  = (state == STREAM) ? pt_sr[127:120] : 8'h00;

endmodule

// File: tb/tb_aes_block_loader.sv
// Randomized scoreboard bench for aes_block_loader with a stub core and a cycle-phase reference model.
module tb_aes_block_loader;
    localparam int R = 4;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] M0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] pt_in = '0;
    logic [127:0] cipher_in = '1;
    logic         in_ready, core_rst, out_valid;
    logic [7:0]   key_byte, msg_byte;
    logic [127:0] ct_out;
`ifdef AES_LOADER_CNT_EN
    logic [15:0]  blk_count;
    logic [15:0]  m_count = '0;
`endif

    int checks = 0;
    int fails = 0;
    logic [127:0] exp_q[$];

    bit           busy = 0;
    bit           leaving = 0;
    bit           or_hold = 1;
    int           ph = 0;
    int           done_cnt = 0;
    logic [127:0] mk, mm, acc_k, acc_m;

    aes_block_loader #(.RUN_CYCLES(R)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .key_in(key_in), .pt_in(pt_in), .core_rst(core_rst),
        .key_byte(key_byte), .msg_byte(msg_byte), .cipher_in(cipher_in),
        .out_valid(out_valid), .out_ready(out_ready), .ct_out(ct_out)
`ifdef AES_LOADER_CNT_EN
        , .blk_count(blk_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rot64(input logic [127:0] x);
        return {x[63:0], x[127:64]};
    endfunction

    // Stand-in core: any reversible mix of the streamed bytes, pinned so (K0,M0) yields C0.
    function automatic logic [127:0] fake_core(input logic [127:0] k, input logic [127:0] m);
        return k ^ rot64(m) ^ K0 ^ rot64(M0) ^ C0;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t ph=%0d)", name, act, exp, $time, ph);
        end
    endtask

    // Reference model: job phase counted in cycles since the accept cycle.
    always @(negedge clk) begin
        if (rst) begin
            busy = 0;
            leaving = 0;
            exp_q.delete();
        end else begin
            if (leaving) begin
                busy = 0;
                leaving = 0;
            end else if (busy) begin
                ph++;
            end
`ifdef AES_LOADER_CNT_EN
            chk("blk_count", blk_count, m_count);
`endif
            if (!busy) begin
                chk("idle_in_ready", in_ready, 1'b1);
                chk("idle_core_rst", core_rst, 1'b1);
                chk("idle_out_valid", out_valid, 1'b0);
                chk("idle_bytes", {key_byte, msg_byte}, 16'h0);
            end else if (ph == 1) begin
                chk("crst_core_rst", core_rst, 1'b1);
                chk("crst_in_ready", in_ready, 1'b0);
                chk("crst_bytes", {key_byte, msg_byte}, 16'h0);
                chk("crst_out_valid", out_valid, 1'b0);
            end else if (ph <= 17) begin
                chk("stream_core_rst", core_rst, 1'b0);
                chk("stream_in_ready", in_ready, 1'b0);
                chk("stream_key_byte", key_byte, mk[127-8*(ph-2) -: 8]);
                chk("stream_msg_byte", msg_byte, mm[127-8*(ph-2) -: 8]);
                acc_k = {acc_k[119:0], key_byte};
                acc_m = {acc_m[119:0], msg_byte};
            end else if (ph <= 17 + R) begin
                chk("wait_core_rst", core_rst, 1'b0);
                chk("wait_bytes", {key_byte, msg_byte}, 16'h0);
                chk("wait_out_valid", out_valid, 1'b0);
                chk("wait_in_ready", in_ready, 1'b0);
            end else begin
                chk("done_out_valid", out_valid, 1'b1);
                chk("done_in_ready", in_ready, 1'b0);
                chk("done_core_rst", core_rst, 1'b0);
                chk("done_bytes", {key_byte, msg_byte}, 16'h0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1'b1, 1'b0);
                end else begin
                    chk("ct_out", ct_out, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        leaving = 1;
                        done_cnt++;
`ifdef AES_LOADER_CNT_EN
                        m_count = m_count + 16'd1;
`endif
                    end
                end
            end
            if (!busy && in_valid) begin
                busy = 1;
                ph = 0;
                mk = key_in;
                mm = pt_in;
                acc_k = '0;
                acc_m = '0;
            end
        end
        cipher_in = (busy && ph >= 18 && ph <= 17 + R) ? fake_core(acc_k, acc_m) : '1;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = or_hold ? 1'b0 : ($urandom_range(0, 2) == 0);
        end
    end

    task automatic issue(input logic [127:0] k, input logic [127:0] m, input bit keep);
        int n;
        n = 0;
        key_in = k;
        pt_in = m;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                chk("accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        exp_q.push_back(fake_core(k, m));
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int t;
        t = 0;
        while (done_cnt < n && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("jobs_completed", done_cnt, n);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] k1, m1;
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_core_rst", core_rst, 1'b1);
        chk("rst_ct_out", ct_out, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector, result held for 10+ cycles; in_valid stays high into a second job.
        k1 = rnd128();
        m1 = rnd128();
        or_hold = 1;
        issue(K0, M0, 1);
        key_in = k1;
        pt_in = m1;
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("first_valid_seen", out_valid, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("held_ct_out", ct_out, C0);
        or_hold = 0;
        issue(k1, m1, 0);
        wait_done(2);

        for (int i = 0; i < 6; i++) begin
            bit keep;
            keep = ($urandom_range(0, 1) == 1);
            issue(rnd128(), rnd128(), keep);
            if (!keep) repeat ($urandom_range(0, 5)) @(posedge clk);
        end
        in_valid = 1'b0;
        wait_done(8);

        // Abort mid-stream at byte index 7.
        issue(rnd128(), rnd128(), 0);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_core_rst", core_rst, 1'b1);
        chk("abort_bytes", {key_byte, msg_byte}, 16'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_ct_out", ct_out, '0);
        @(posedge clk);
        #1;

`ifdef AES_LOADER_CNT_EN
        force dut.blk_count = 16'hFFFF;
        #1;
        release dut.blk_count;
        m_count = 16'hFFFF;
`endif
        issue(rnd128(), rnd128(), 0);
        wait_done(9);
        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
`ifdef AES_LOADER_CNT_EN
        #1;
        chk("blk_count_wrap", blk_count, 16'h0000);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule
